// File: rtl/dispatcher.sv
// dispatcher: numbers arriving customers, queues them in FIFO order and loads the lowest idle counter.
// Optional DISP_STATS_EN builds a saturating dispatch count on srv_cnt; otherwise srv_cnt is tied to 0.
module dispatcher #(
  parameter int DT_SZ   = 4,
  parameter int N_CTR   = 3,
  parameter int Q_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arr,
  input  logic [DT_SZ-1:0]           arr_dt,
  input  logic [N_CTR-1:0]           busy,
  output logic [N_CTR-1:0]           ld,
  output logic [DT_SZ-1:0]           dn,
  output logic [DT_SZ-1:0]           dt,
  output logic [$clog2(Q_DEPTH):0]   q_cnt,
  output logic                       full,
  output logic                       drop,
  output logic [DT_SZ-1:0]           next_num,
  output logic [15:0]                srv_cnt
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(Q_DEPTH);
  logic [2*DT_SZ-1:0] mem [Q_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [N_CTR-1:0]   elig, pick;
  logic [DT_SZ-1:0]   dt_in;
  logic               pop, push;
  // ld masks the counter for the cycle before its busy flag rises
  assign elig  = ~busy & ~ld;
  assign pick  = elig & (~elig + N_CTR'(1));
  assign pop   = (q_cnt != '0) && (|elig);
  assign push  = arr && (!full || pop);
  assign full  = q_cnt == DEPTH;
  assign dt_in = (arr_dt == '0) ? DT_SZ'(1) : arr_dt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ld       <= '0;
      dn       <= '0;
      dt       <= '0;
      q_cnt    <= '0;
      drop     <= 1'b0;
      next_num <= DT_SZ'(1);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      ld <= pop ? pick : '0;
      if (pop) begin
        {dn, dt} <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        next_num <= (&next_num) ? DT_SZ'(1) : next_num + DT_SZ'(1);
      end
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
      drop  <= arr && !push;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {next_num, dt_in};
`ifdef DISP_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) srv_cnt <= '0;
    else if (pop && !(&srv_cnt)) srv_cnt <= srv_cnt + 16'd1;
`else
  assign srv_cnt = '0;
`endif
endmodule
